cdp1802_uart: RTL and testbench

CDP1802_UART -- requirements
Module: cdp1802_uart

---
 rtl/cdp1802_uart_pkg.sv | 29 ++
 rtl/uart_fifo.sv | 49 ++++
 rtl/cdp1802_uart.sv | 213 +++++++++++++++++++++
 tb/tb_cdp1802_uart.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cdp1802_uart_pkg.sv
// rtl/cdp1802_uart_pkg.sv - shared port numbers, flag indices and FSM encodings for cdp1802_uart
package cdp1802_uart_pkg;

  // CPU I/O port numbers decoded from n
  localparam logic [2:0] PORT_TX  = 3'd1;
  localparam logic [2:0] PORT_RX  = 3'd2;
  localparam logic [2:0] PORT_CLR = 3'd3;

  // EF flag bit positions
  localparam int EF_TX_READY = 0;
  localparam int EF_RX_AVAIL = 1;
  localparam int EF_OVERRUN  = 2;
  localparam int EF_FRAMING  = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - small synchronous FIFO with extra-bit pointers
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push into a full FIFO with a pop still lands
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointer update; wrap comes for free from the extra MSB
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write, no reset needed since empty masks stale contents
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cdp1802_uart.sv
// rtl/cdp1802_uart.sv - CDP1802 I/O-port UART with TX/RX FIFOs and sticky error flags
module cdp1802_uart
  import cdp1802_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] n,
  input  logic [7:0] bus_out,
  output logic [7:0] bus_in,
  output logic [3:0] EF,
  input  logic       rxd,
  output logic       txd
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic       tx_push, rx_pop, flag_clr;
  logic [7:0] tx_head, rx_head;
  logic       tx_empty, tx_full, rx_empty, rx_full;

  assign tx_push  = (n == PORT_TX);
  assign rx_pop   = (n == PORT_RX);
  assign flag_clr = (n == PORT_CLR);

  // ---------------- transmitter ----------------
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_bit_end, tx_load, tx_line;

  assign tx_bit_end = (tx_cnt == BIT_LAST);

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (bus_out),
    .pop       (tx_load),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  // TX state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  // TX next state; STOP chains straight into START when more bytes wait
  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (!tx_empty) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_next = tx_empty ? TX_IDLE : TX_START;
    endcase
  end

  // TX outputs: FIFO pop on load and the line level for the current bit
  always_comb begin
    tx_load = 1'b0;
    tx_line = 1'b1;
    unique case (tx_state)
      TX_IDLE:  tx_load = !tx_empty;
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift[0];
      TX_STOP:  tx_load = tx_bit_end && !tx_empty;
    endcase
  end

  // TX datapath: bit timer, bit index, shifter and registered line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      txd <= tx_line;
      if (tx_state == TX_IDLE || tx_state != tx_next || (tx_state == TX_DATA && tx_bit_end))
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + 16'd1;
      if (tx_load) begin
        tx_shift <= tx_head;
        tx_bit   <= '0;
      end else if (tx_state == TX_DATA && tx_bit_end) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t   rx_state, rx_next;
  logic        sync1, rx_s, rx_d, rx_armed;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_bit_end, rx_fall, rx_sample, rx_push, rx_frame_err;
  logic        overrun, framing;

  assign rx_bit_end = (rx_cnt == BIT_LAST);
  assign rx_fall    = rx_d && !rx_s;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  // RX state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // RX next state; START rechecks the line at mid-bit to reject glitches
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_armed && rx_fall) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_bit_end) rx_next = RX_IDLE;
    endcase
  end

  // RX outputs: data sample strobe, good-frame push and framing error
  always_comb begin
    rx_sample    = 1'b0;
    rx_push      = 1'b0;
    rx_frame_err = 1'b0;
    unique case (rx_state)
      RX_DATA: rx_sample = rx_bit_end;
      RX_STOP: begin
        rx_push      = rx_bit_end && rx_s;
        rx_frame_err = rx_bit_end && !rx_s;
      end
      default: ;
    endcase
  end

  // RX datapath: bit timer, shifter, and re-arm after a framing error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_armed <= 1'b1;
    end else begin
      if (rx_state == RX_IDLE || rx_state != rx_next || rx_sample)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == RX_IDLE) begin
        rx_bit <= '0;
      end else if (rx_sample) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
      if (rx_frame_err)
        rx_armed <= 1'b0;
      else if (rx_state == RX_IDLE && rx_s)
        rx_armed <= 1'b1;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
      framing <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_pop) overrun <= 1'b1;
      else if (flag_clr)                 overrun <= 1'b0;
      if (rx_frame_err)                  framing <= 1'b1;
      else if (flag_clr)                 framing <= 1'b0;
    end
  end

  assign bus_in              = rx_empty ? 8'h00 : rx_head;
  assign EF[EF_TX_READY]     = !tx_full;
  assign EF[EF_RX_AVAIL]     = !rx_empty;
  assign EF[EF_OVERRUN]      = overrun;
  assign EF[EF_FRAMING]      = framing;

endmodule

// File: tb/tb_cdp1802_uart.sv
// tb/tb_cdp1802_uart.sv - directed self-checking bench for cdp1802_uart
module tb_cdp1802_uart;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] n;
  logic [7:0] bus_out;
  logic       rxd;
  logic [7:0] bus_in;
  logic [3:0] EF;
  logic       txd;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cdp1802_uart #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .n       (n),
    .bus_out (bus_out),
    .bus_in  (bus_in),
    .EF      (EF),
    .rxd     (rxd),
    .txd     (txd)
  );

  task automatic step(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_op(input logic [2:0] nv, input logic [7:0] d);
    n       = nv;
    bus_out = d;
    step(1);
    n       = 3'd0;
    bus_out = 8'h00;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    step(4);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(4);
    end
    rxd = stop_bit;
    step(4);
    rxd = 1'b1;
    step(3);
  endtask

  // Walk txd clock by clock from frame offset 'from' (0 = first start-bit clock)
  task automatic check_frame(input logic [7:0] b, input int from);
    logic [7:0] bv;
    bv = b;
    for (int i = from; i < 40; i++) begin
      int   idx;
      logic e;
      idx = i / 4;
      if (idx == 0)      e = 1'b0;
      else if (idx == 9) e = 1'b1;
      else               e = bv[idx-1];
      chk($sformatf("tx_%02h_slot%0d", bv, idx), {31'd0, txd}, {31'd0, e});
      step(1);
    end
  endtask

  initial begin
    logic seen_low;
    reset   = 1'b1;
    n       = 3'd0;
    bus_out = 8'h00;
    rxd     = 1'b1;
    step(2);
    chk("rst_txd",    {31'd0, txd}, 32'd1);
    chk("rst_ef",     {28'd0, EF},  32'h1);
    chk("rst_bus_in", {24'd0, bus_in}, 32'h0);
    reset = 1'b0;
    step(2);

    // Single byte transmit
    cpu_op(3'd1, 8'hA5);
    chk("a5_ef0", {31'd0, EF[0]}, 32'd1);
    chk("a5_txd_w+0", {31'd0, txd}, 32'd1);
    step(1);
    chk("a5_txd_w+1", {31'd0, txd}, 32'd1);
    step(1);
    check_frame(8'hA5, 0);
    chk("a5_idle_after", {31'd0, txd}, 32'd1);
    step(3);

    // Five back-to-back writes, four queued behind the shifter
    for (int i = 1; i <= 5; i++) cpu_op(3'd1, 8'(i));
    chk("burst_ef0_full", {31'd0, EF[0]}, 32'd0);
    check_frame(8'h01, 2);
    for (int i = 2; i <= 5; i++) check_frame(8'(i), 0);
    chk("burst_idle_after", {31'd0, txd}, 32'd1);
    chk("burst_ef0_after", {31'd0, EF[0]}, 32'd1);

    // Receive one byte, then pop it
    send_rx(8'h3C, 1'b1);
    chk("rx3c_ef1", {31'd0, EF[1]}, 32'd1);
    chk("rx3c_bus_in", {24'd0, bus_in}, 32'h3C);
    cpu_op(3'd2, 8'h00);
    chk("rx3c_pop_ef1", {31'd0, EF[1]}, 32'd0);
    chk("rx3c_pop_bus_in", {24'd0, bus_in}, 32'h00);

    // Overrun: five frames into a four-deep FIFO
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    send_rx(8'h44, 1'b1);
    chk("ovr_before_ef2", {31'd0, EF[2]}, 32'd0);
    send_rx(8'h55, 1'b1);
    chk("ovr_ef2", {31'd0, EF[2]}, 32'd1);
    chk("ovr_head", {24'd0, bus_in}, 32'h11);
    cpu_op(3'd2, 8'h00);
    chk("ovr_pop2", {24'd0, bus_in}, 32'h22);
    cpu_op(3'd2, 8'h00);
    chk("ovr_pop3", {24'd0, bus_in}, 32'h33);
    cpu_op(3'd2, 8'h00);
    chk("ovr_pop4", {24'd0, bus_in}, 32'h44);
    cpu_op(3'd2, 8'h00);
    chk("ovr_empty_bus_in", {24'd0, bus_in}, 32'h00);
    chk("ovr_empty_ef", {28'd0, EF}, 32'h5);
    cpu_op(3'd2, 8'h00);
    chk("ovr_pop_empty_ef", {28'd0, EF}, 32'h5);
    cpu_op(3'd3, 8'h00);
    chk("ovr_clr_ef", {28'd0, EF}, 32'h1);

    // Framing error, then a good frame to prove the receiver re-arms
    send_rx(8'h5A, 1'b0);
    chk("frm_ef", {28'd0, EF}, 32'h9);
    cpu_op(3'd3, 8'h00);
    chk("frm_clr_ef", {28'd0, EF}, 32'h1);
    send_rx(8'h81, 1'b1);
    chk("rearm_bus_in", {24'd0, bus_in}, 32'h81);
    cpu_op(3'd2, 8'h00);
    chk("rearm_pop_ef", {28'd0, EF}, 32'h1);

    // One-clock low glitch is rejected silently
    rxd = 1'b0;
    step(1);
    rxd = 1'b1;
    step(50);
    chk("glitch_ef", {28'd0, EF}, 32'h1);
    chk("glitch_bus_in", {24'd0, bus_in}, 32'h00);

    // Reset during data bit 3 of 8'hF0 with a second byte queued
    cpu_op(3'd1, 8'hF0);
    cpu_op(3'd1, 8'h33);
    step(18);
    chk("rstmid_bit3_low", {31'd0, txd}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rstmid_txd", {31'd0, txd}, 32'd1);
    chk("rstmid_ef", {28'd0, EF}, 32'h1);
    chk("rstmid_bus_in", {24'd0, bus_in}, 32'h00);
    step(2);
    reset = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1) seen_low = 1'b1;
      step(1);
    end
    chk("rstmid_no_frame", {31'd0, seen_low}, 32'd0);
    chk("rstmid_final_ef", {28'd0, EF}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
